// File: rtl/irq_timer_pkg.sv
// rtl/irq_timer_pkg.sv - shared register map, TCON bit indices and default base address for irq_timer
package irq_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;
    localparam logic [3:0] OFF_TPRE = 4'hC;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    localparam int TPRE_W = 16;

endpackage

// File: rtl/irq_timer_prescaler.sv
// rtl/irq_timer_prescaler.sv - timer_prescaler: divides the enabled clock into ticks every tpre+1 cycles
module timer_prescaler
    import irq_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [TPRE_W-1:0] tpre,
    input  logic              enable,
    input  logic              clear,
    output logic              tick
);

    logic [TPRE_W-1:0] cnt;

    assign tick = enable && (cnt == tpre);

    // Prescale counter: held at zero while disabled or on a TPRE store, wraps at tpre
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt == tpre) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - memory-mapped 32-bit reload timer with level IRQ; optional TPRE under IRQ_TIMER_PRESCALE_EN
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic        hit;
    logic [3:0]  off;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        tick;
    logic        ovf;
    logic        set_status;
    logic [1:0]  unused_addr_lsb;

    assign unused_addr_lsb = Address[1:0];

    assign hit     = (Address[31:4] == BASE_ADDR[31:4]);
    assign off     = {Address[3:2], 2'b00};
    assign wr_th   = MemWr && hit && (off == OFF_TH);
    assign wr_tl   = MemWr && hit && (off == OFF_TL);
    assign wr_tcon = MemWr && hit && (off == OFF_TCON);

`ifdef IRQ_TIMER_PRESCALE_EN
    logic [TPRE_W-1:0] tpre;
    logic              wr_tpre;

    assign wr_tpre = MemWr && hit && (off == OFF_TPRE);

    // TPRE register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tpre <= '0;
        end else if (wr_tpre) begin
            tpre <= WriteData[TPRE_W-1:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tpre   (tpre),
        .enable (tcon[TCON_EN]),
        .clear  (wr_tpre),
        .tick   (tick)
    );
`else
    assign tick = tcon[TCON_EN];
`endif

    // Tick decisions use the pre-edge TCON, so a store clearing enable still lets this edge count
    assign ovf        = tick && (tl == 32'hFFFF_FFFF);
    assign set_status = ovf && tcon[TCON_IE];

    // TH reload register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th <= '0;
        end else if (wr_th) begin
            th <= WriteData;
        end
    end

    // TL counter: a store beats the tick; an overflow reloads from the pre-edge TH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tl <= '0;
        end else if (wr_tl) begin
            tl <= WriteData;
        end else if (ovf) begin
            tl <= th;
        end else if (tick) begin
            tl <= tl + 32'd1;
        end
    end

    // TCON: a store on the overflow edge cannot drop the status event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon <= {WriteData[TCON_ST] | set_status, WriteData[TCON_IE], WriteData[TCON_EN]};
        end else if (set_status) begin
            tcon[TCON_ST] <= 1'b1;
        end
    end

    assign IRQ = tcon[TCON_IE] & tcon[TCON_ST];

    // Load data mux, zero outside the window or when not reading
    always_comb begin
        ReadData = '0;
        if (MemRd && hit) begin
            case (off)
                OFF_TH:   ReadData = th;
                OFF_TL:   ReadData = tl;
                OFF_TCON: ReadData = {29'd0, tcon};
`ifdef IRQ_TIMER_PRESCALE_EN
                OFF_TPRE: ReadData = {{(32-TPRE_W){1'b0}}, tpre};
`endif
                default:  ReadData = '0;
            endcase
        end
    end

endmodule
